// File: rtl/mau_pkg.sv
// Shared types and helpers for the load/store unit.
package mau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    C_OK      = 2'd0,
    C_ADEL    = 2'd1,
    C_ADES    = 2'd2,
    C_TIMEOUT = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Number of bytes moved by an access of the given size.
  function automatic logic [3:0] bytes_of(input size_e s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response and data-memory bus of the load/store unit.
interface mem_access_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]              rsp_cause;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_ack;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // Unit side.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_cause,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // Core + memory side.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_cause,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mau_load_align.sv
// Combinational load alignment: pick the addressed lane and extend it.
module mau_load_align
  import mau_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]                 word,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]       offset,
  input  size_e                                 size,
  input  logic                                  is_unsigned,
  output logic [DATA_WIDTH-1:0]                 data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic                  sign;
  int unsigned           nbits;

  // Shift the addressed bytes down, then sign- or zero-fill above the access size.
  always_comb begin
    data    = '0;
    shifted = word >> {offset, 3'b000};
    nbits   = 32'(bytes_of(size)) * 8;
    sign    = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (i == nbits - 1) sign = shifted[i];
    end
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      data[i] = (i < nbits) ? shifted[i] : (sign & ~is_unsigned);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: request latch, alignment check, memory handshake with watchdog.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic              CLK,
  input logic              RST,
  mem_access_unit_if.slave bus
);

  localparam int unsigned BEW  = DATA_WIDTH / 8;
  localparam int unsigned OFFW = $clog2(BEW);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  size_e                 size_q, size_d;
  logic                  uns_q, uns_d;
  logic [OFFW-1:0]       off_q, off_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BEW-1:0]        mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  cause_e                rsp_cause_q, rsp_cause_d;

  logic [3:0]            req_bytes;
  logic [OFFW-1:0]       req_off;
  logic                  req_illegal;
  logic                  req_bad;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_WIDTH-1:0] load_data;

  mau_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .word        (bus.mem_rdata),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (load_data)
  );

  // Decode the incoming request: size legality, misalignment, lane-replicated store data.
  always_comb begin
    req_bytes   = bytes_of(size_e'(bus.req_size));
    req_off     = bus.req_addr[OFFW-1:0];
    req_illegal = 32'(req_bytes) > BEW;
    req_bad     = req_illegal || ((32'(req_off) & (32'(req_bytes) - 1)) != 0);
    wdata_rep   = '0;
    // Offsets are size-aligned, so lane i always carries store byte (i mod size).
    for (int unsigned i = 0; i < BEW; i++) begin
      wdata_rep[8*i +: 8] = bus.req_wdata[8*(i & (32'(req_bytes) - 1)) +: 8];
    end
  end

  // FSM next state and all registered outputs.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_cause_d = rsp_cause_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d   = bus.req_we;
          size_d = size_e'(bus.req_size);
          uns_d  = bus.req_unsigned;
          off_d  = req_off;
          if (req_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_cause_d = (bus.req_we || req_illegal) ? C_ADES : C_ADEL;
          end else begin
            state_d     = ISSUE;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = bus.req_addr & ~ADDR_WIDTH'(BEW - 1);
            mem_be_d    = BEW'(((16'd1 << req_bytes) - 16'd1) << req_off);
            mem_wdata_d = wdata_rep;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_ack) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : load_data;
          rsp_cause_d = C_OK;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(TIMEOUT_CYCLES)) begin
            state_d     = RESP;
            mem_req_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_cause_d = C_TIMEOUT;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      off_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_cause_q <= C_OK;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_cause_q <= rsp_cause_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE) && RST;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_cause = rsp_cause_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 32-bit and 64-bit instances against a byte-level reference model.
module tb_mem_access_unit;

  localparam int TO32 = 4;
  localparam int TO64 = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; sel64 routes the request to one instance.
  logic        sel64 = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;

  mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if32 ();
  mem_access_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) if64 ();

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO32)) u_dut32 (
    .CLK(clk), .RST(rst_n), .bus(if32.slave));
  mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO64)) u_dut64 (
    .CLK(clk), .RST(rst_n), .bus(if64.slave));

  assign if32.req_valid    = req_valid & ~sel64;
  assign if32.req_we       = req_we;
  assign if32.req_size     = req_size;
  assign if32.req_unsigned = req_unsigned;
  assign if32.req_addr     = req_addr;
  assign if32.req_wdata    = req_wdata[31:0];
  assign if32.mem_ack      = mem_ack;
  assign if32.mem_rdata    = mem_rdata[31:0];
  assign if64.req_valid    = req_valid & sel64;
  assign if64.req_we       = req_we;
  assign if64.req_size     = req_size;
  assign if64.req_unsigned = req_unsigned;
  assign if64.req_addr     = req_addr;
  assign if64.req_wdata    = req_wdata;
  assign if64.mem_ack      = mem_ack;
  assign if64.mem_rdata    = mem_rdata;

  logic        o_ready, o_rsp_valid, o_mem_req, o_mem_we;
  logic [63:0] o_rsp_rdata, o_mem_wdata;
  logic [1:0]  o_cause;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_be;
  assign o_ready     = sel64 ? if64.req_ready : if32.req_ready;
  assign o_rsp_valid = sel64 ? if64.rsp_valid : if32.rsp_valid;
  assign o_rsp_rdata = sel64 ? if64.rsp_rdata : {32'h0, if32.rsp_rdata};
  assign o_cause     = sel64 ? if64.rsp_cause : if32.rsp_cause;
  assign o_mem_req   = sel64 ? if64.mem_req   : if32.mem_req;
  assign o_mem_we    = sel64 ? if64.mem_we    : if32.mem_we;
  assign o_mem_addr  = sel64 ? if64.mem_addr  : if32.mem_addr;
  assign o_mem_be    = sel64 ? if64.mem_be    : {4'h0, if32.mem_be};
  assign o_mem_wdata = sel64 ? if64.mem_wdata : {32'h0, if32.mem_wdata};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction, started in an IDLE cycle's low phase; returns in the IDLE cycle after RESP.
  // waits < 0 means memory never acknowledges.
  task automatic run(input bit w64, input bit we, input logic [1:0] sz, input bit uns,
                     input logic [31:0] addr, input logic [63:0] wd, input int waits,
                     input logic [63:0] rword);
    int dw, nbl, to, nb, off, lat, issue_cnt, exp_lat, exp_cause;
    bit bad;
    logic [63:0] exp_rdata, exp_wdata, val;
    logic [7:0]  exp_be;
    dw  = w64 ? 64 : 32;
    nbl = dw / 8;
    to  = w64 ? TO64 : TO32;
    nb  = 1 << sz;
    off = int'(addr % nbl);
    bad = (nb > nbl) || (off % nb != 0);
    if (bad) begin
      exp_cause = (we || nb > nbl) ? 2 : 1;
      exp_lat   = 1;
    end else if (waits >= 0 && waits + 1 <= to) begin
      exp_cause = 0;
      exp_lat   = waits + 2;
    end else begin
      exp_cause = 3;
      exp_lat   = to + 1;
    end
    exp_be = '0;
    exp_wdata = '0;
    val = '0;
    if (!bad) begin
      for (int k = 0; k < nb; k++) exp_be[off + k] = 1'b1;
      for (int i = 0; i < nbl; i++) exp_wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
      for (int k = 0; k < nb; k++) val[8*k +: 8] = rword[8*(off + k) +: 8];
      if (!uns && ((val >> (8*nb - 1)) & 64'd1) == 64'd1)
        for (int b = 8*nb; b < dw; b++) val[b] = 1'b1;
    end
    exp_rdata = (exp_cause == 0 && !we) ? val : 64'h0;

    sel64 = w64; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    mem_ack = 1'b1;                      // stray ack while idle must be ignored
    mem_rdata = {$urandom, $urandom};
    #1 chk("req_ready_idle", {63'h0, o_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0; mem_ack = 1'b0;
    req_addr = $urandom; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_wdata = {$urandom, $urandom};
    lat = 0;
    issue_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      if (o_rsp_valid) begin
        lat = n;
        break;
      end
      if (o_mem_req) issue_cnt++;
      if (n == 1 && !bad) begin
        chk("mem_addr", {32'h0, o_mem_addr}, {32'h0, addr - 32'(off)});
        chk("mem_be", {56'h0, o_mem_be}, {56'h0, exp_be});
        chk("mem_we", {63'h0, o_mem_we}, {63'h0, we});
        if (we) chk("mem_wdata", o_mem_wdata, exp_wdata);
      end
      mem_ack = (waits >= 0 && n == waits + 1);
      mem_rdata = mem_ack ? rword : {$urandom, $urandom};
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("issue_cycles", 64'(issue_cnt), 64'(exp_lat - 1));
    chk("cause", {62'h0, o_cause}, 64'(exp_cause));
    chk("rdata", o_rsp_rdata, exp_rdata);
    chk("mem_req_in_resp", {63'h0, o_mem_req}, 64'd0);
    @(negedge clk);
    chk("rsp_one_cycle", {63'h0, o_rsp_valid}, 64'd0);
  endtask

  initial begin
    int seen, w, sz, to;
    bit w64;
    logic [31:0] a;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    chk("rst_ready32", {63'h0, if32.req_ready}, 64'd0);
    chk("rst_ready64", {63'h0, if64.req_ready}, 64'd0);
    chk("rst_memreq32", {63'h0, if32.mem_req}, 64'd0);
    chk("rst_rspv64", {63'h0, if64.rsp_valid}, 64'd0);
    chk("rst_be64", {56'h0, if64.mem_be}, 64'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", {63'h0, if32.req_ready}, 64'd1);

    // Directed cases.
    run(0, 0, 2'd0, 0, 32'h0000_0003, 64'h0, 0, 64'h80FF_FF7F);
    run(0, 1, 2'd1, 0, 32'h0000_0102, 64'h1234_ABCD, 1, 64'h0);
    run(0, 0, 2'd2, 0, 32'h0000_0006, 64'h0, 0, 64'h0);
    run(0, 1, 2'd1, 0, 32'h0000_0001, 64'h0, 0, 64'h0);
    run(0, 0, 2'd2, 1, 32'h0000_0010, 64'h0, -1, 64'h0);
    run(0, 0, 2'd2, 1, 32'h0000_0010, 64'h0, TO32 - 1, 64'h1357_9BDF);
    run(1, 0, 2'd2, 1, 32'h0000_000C, 64'h0, 0, 64'h8765_4321_0000_0000);
    run(1, 1, 2'd3, 0, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 2, 64'h0);
    run(1, 0, 2'd1, 0, 32'h0000_0006, 64'h0, -1, 64'h0);
    run(0, 0, 2'd3, 0, 32'h0000_0008, 64'h0, 0, 64'h0);

    // Reset during ISSUE abandons the access.
    sel64 = 1'b0; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("issue_before_rst", {63'h0, o_mem_req}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("memreq_after_rst", {63'h0, o_mem_req}, 64'd0);
    chk("ready_in_rst", {63'h0, o_ready}, 64'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_release", {63'h0, o_ready}, 64'd1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_rsp_valid) seen++;
    end
    chk("no_rsp_after_rst", 64'(seen), 64'd0);
    run(0, 0, 2'd1, 0, 32'h0000_0022, 64'h0, 0, 64'h9ABC_0000);

    // Randomized traffic on both widths.
    for (int t = 0; t < 80; t++) begin
      w64 = 1'($urandom);
      to  = w64 ? TO64 : TO32;
      sz  = $urandom_range(0, 3);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      w   = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, to + 1);
      run(w64, 1'($urandom), 2'(sz), 1'($urandom), a, {$urandom, $urandom}, w,
          {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store unit for the multi-cycle MIPS core. It sits between the datapath (ALU_REG_OUT as address, Reg2_Out as store data) and a word-wide data memory with a request/acknowledge handshake. It replaces fixed 32-bit byte/half-word extension muxing with lane-aware alignment for 32- or 64-bit datapaths. It also adds misalignment detection and a bus-timeout watchdog that report a cause code for the CAUSE register.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath and memory word width; legal values 32 or 64.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 15, maximum cycles in ISSUE without mem_ack; range 1..255.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  reset, synchronous and active-low.
- req_valid  in  1  core request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word32, 3 = dword64.
- req_unsigned  in  1  zero-extend the load result; 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_cause  out  2  0 = OK, 1 = misaligned load, 2 = misaligned store or illegal size, 3 = bus timeout.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  word-aligned address; low log2(DATA_WIDTH/8) bits are 0.
- mem_be  out  DATA_WIDTH/8  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_ack  in  1  memory done; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  read word.

## Operation
- **States:**
  - IDLE: req_ready = 1.
  - ISSUE: mem_req = 1.
  - RESP: rsp_valid = 1.
- **Acceptance:**
  - Occurs in IDLE when req_valid = 1.
  - All request fields are latched at acceptance; the req_* inputs are ignored afterwards.
- **Alignment check on the latched request:**
  - Offset = addr[log2(DATA_WIDTH/8)-1:0].
  - The request is misaligned if the offset is not a multiple of the access size in bytes.
  - req_size = 3 with DATA_WIDTH = 32 is illegal.
  - Either case goes IDLE→RESP with the cause set (1 for a load; 2 for a store or illegal size). No memory access is made.
- **Legal requests:** IDLE→ISSUE.
  - mem_be = ((1<<bytes)-1) << offset.
  - mem_wdata = the low bytes of wdata replicated across all lanes.
- **In ISSUE:**
  - mem_ack = 1: capture mem_rdata, go to RESP with cause 0.
  - Otherwise the watchdog counter increments. When it reaches TIMEOUT_CYCLES, go to RESP with cause 3 and drop mem_req.
  - If mem_ack arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the ack wins (cause 0).
- **Load data:**
  - Shift the captured word right by offset×8.
  - Mask to the access size.
  - Sign- or zero-extend to DATA_WIDTH per req_unsigned.
  - Word32 on a 64-bit datapath is extended the same way.
- **RESP:** rsp_valid for exactly one cycle, then IDLE.
- mem_ack while mem_req = 0 is ignored.

## Timing
- **Reset (RST = 0 at an edge):**
  - State → IDLE; the watchdog counter is cleared.
  - Every output is 0, including req_ready, while RST = 0.
  - req_ready goes to 1 in the first cycle after release.
- **Reset mid-transaction:** the transaction is abandoned. mem_req is 0 from the next cycle and no rsp_valid is produced.
- **Latency from acceptance to rsp_valid:**
  - Aligned access with immediate ack: 2 cycles.
  - Each wait cycle adds 1.
  - Misaligned or illegal: 1 cycle.
  - Timeout: TIMEOUT_CYCLES+1 cycles.
- **Registered outputs:** all mem_* and rsp_* outputs come from registers; there is no combinational path from req_* to mem_*.
- req_ready is the decoded state (IDLE) gated by RST.
- **Back-to-back:** a new request is accepted the cycle after RESP. Throughput is 1 access per 3 cycles minimum.

## Structure
- Package mau_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD);
  - cause enum (C_OK, C_ADEL, C_ADES, C_TIMEOUT);
  - state enum (IDLE, ISSUE, RESP);
  - localparam function for bytes_of(size).
- Sub-module mau_load_align is purely combinational. Inputs: word, offset, size, unsigned. Output: extended data. It is reusable by a future cache-line path.
- The top level holds the FSM, request latches, watchdog counter, byte-enable and replication logic.

## Test plan
- **32-bit signed byte load:** addr 0x0000_0003, mem_rdata 0x80FF_FF7F, ack in first ISSUE cycle. Expect mem_addr 0x0, mem_be 4'b1000, rsp_rdata 0xFFFF_FF80, cause 0, rsp_valid 2 cycles after acceptance.
- **32-bit half store:** addr 0x0000_0102, wdata 0x1234_ABCD. Expect mem_be 4'b1100, mem_wdata 0xABCD_ABCD, mem_we 1, rsp_rdata 0.
- **Misaligned accesses:** word load at addr 0x0000_0006 → cause 1, mem_req never asserted, rsp 1 cycle after acceptance. Half store at 0x0000_0001 → cause 2.
- **Timeout:** with TIMEOUT_CYCLES = 4 and no ack → mem_req high 4 cycles, then rsp cause 3. A second run acks exactly on cycle 4 → cause 0.
- **DATA_WIDTH = 64:**
  - Unsigned word load at 0x0C, mem_rdata 0x8765_4321_0000_0000 → rsp_rdata 0x0000_0000_8765_4321.
  - dword at 0x08 → mem_be 8'hFF.
  - With DATA_WIDTH = 32, req_size 3 → cause 2.
- **Reset mid-ISSUE:** RST low for 1 cycle → mem_req 0 the next cycle, no rsp_valid, req_ready 1 the cycle after release; a following load completes normally.
